// File: rtl/ibwt_pkg.sv
// ibwt_pkg: shared types and constants for the streaming inverse BWT decoder.
//   state_t       - decoder FSM states
//   ALPHA_SIZE    - number of distinct byte values
//   TERM_CHAR_DEF - default block terminator ('$')
package ibwt_pkg;
  localparam int         ALPHA_SIZE    = 256;
  localparam logic [7:0] TERM_CHAR_DEF = 8'h24;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    PREFIX,
    WALK,
    FINAL,
    EMIT
  } state_t;
endpackage

// File: rtl/ibwt_if.sv
// ibwt_if: character-stream interface shared with bwt_top.
// Handshake: start qualifies input_string_char for exactly one cycle and there
// is no backpressure, so the producer never waits. valid_out qualifies
// output_string_char for one cycle, and the consumer must take it on that
// cycle. busy spans the first accepted byte to the last emitted byte. err is
// a sticky format flag. dbg_state mirrors the decoder FSM.
//   master : producer/consumer side (drives start, input_string_char)
//   slave  : decoder side
interface ibwt_if;
  import ibwt_pkg::*;

  logic       start;
  logic [7:0] input_string_char;
  logic [7:0] output_string_char;
  logic       valid_out;
  logic       busy;
  logic       err;
  state_t     dbg_state;

  modport master (
    output start, input_string_char,
    input  output_string_char, valid_out, busy, err, dbg_state
  );

  modport slave (
    input  start, input_string_char,
    output output_string_char, valid_out, busy, err, dbg_state
  );
endinterface

// File: rtl/ibwt_count_table.sv
// ibwt_count_table: per-byte histogram hist[] and exclusive prefix table C[].
//   i_inc_en/i_inc_char/o_old_cnt : bump hist[char], o_old_cnt is the count before the bump
//   i_clear                       : zero the whole histogram (wins over an increment)
//   i_prefix_en/i_prefix_k        : one step of the prefix sweep, C[k] <= sum of hist[0..k-1]
//   i_lookup_char/o_c_val         : combinational C[] read used while walking
module ibwt_count_table
  import ibwt_pkg::*;
#(
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_inc_en,
  input  logic [7:0]       i_inc_char,
  output logic [CNT_W-1:0] o_old_cnt,
  input  logic             i_clear,
  input  logic             i_prefix_en,
  input  logic [7:0]       i_prefix_k,
  input  logic [7:0]       i_lookup_char,
  output logic [CNT_W-1:0] o_c_val
);
  logic [CNT_W-1:0] r_hist [ALPHA_SIZE];
  logic [CNT_W-1:0] r_c    [ALPHA_SIZE];
  logic [CNT_W-1:0] r_sum;
  logic [CNT_W-1:0] w_base;

  assign o_old_cnt = r_hist[i_inc_char];
  assign o_c_val   = r_c[i_lookup_char];
  // The sweep restarts its running sum at k=0, so no separate init is needed.
  assign w_base    = (i_prefix_k == 8'd0) ? '0 : r_sum;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int a = 0; a < ALPHA_SIZE; a++) r_hist[a] <= '0;
      r_sum <= '0;
    end else begin
      if (i_clear) begin
        for (int a = 0; a < ALPHA_SIZE; a++) r_hist[a] <= '0;
      end else if (i_inc_en) begin
        r_hist[i_inc_char] <= o_old_cnt + CNT_W'(1);
      end
      if (i_prefix_en) r_sum <= w_base + r_hist[i_prefix_k];
    end
  end

  // C[] is fully rewritten by every sweep before it is read.
  always_ff @(posedge clk) begin
    if (i_prefix_en) r_c[i_prefix_k] <= w_base;
  end
endmodule

// File: rtl/ibwt_top.sv
// ibwt_top: streaming inverse Burrows-Wheeler transform.
// Takes the BWT last column one byte per start pulse, rebuilds the original
// terminated string by LF-mapping, then emits it first character first.
//   clk  : system clock, rising edge
//   rst  : asynchronous reset, active-low
//   bus  : ibwt_if.slave (start, input_string_char, output_string_char,
//          valid_out, busy, err, dbg_state)
// Optional build macro IBWT_CHECK_EN: validates the terminator during load and
// aborts the block with err=1 on malformed input; otherwise err is tied 0.
module ibwt_top
  import ibwt_pkg::*;
#(
  parameter int         STRING_LEN = 32,
  parameter logic [7:0] TERM_CHAR  = TERM_CHAR_DEF
) (
  input  logic  clk,
  input  logic  rst,
  ibwt_if.slave bus
);
  localparam int IDX_W = $clog2(STRING_LEN);
  localparam int CNT_W = IDX_W + 1;
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(STRING_LEN - 1);
  localparam logic [IDX_W-1:0] WALK_START = IDX_W'(STRING_LEN - 2);

  state_t           r_state;
  logic [IDX_W-1:0] r_idx;   // load index, then walk j, then emit index
  logic [7:0]       r_k;
  logic [IDX_W-1:0] r_row;
  logic             r_valid;
  logic [7:0]       r_char;
  logic             r_busy;

  logic [7:0]       r_l    [STRING_LEN];
  logic [CNT_W-1:0] r_rank [STRING_LEN];
  logic [7:0]       r_out  [STRING_LEN];

  logic             w_accept_first, w_accept_load, w_load_last, w_emit_last;
  logic             w_abort, w_clear;
  logic [CNT_W-1:0] w_old_cnt, w_c_val, w_row_sum;
  logic [7:0]       w_walk_char;

  assign w_accept_first = (r_state == IDLE) && bus.start;
  assign w_accept_load  = (r_state == LOAD) && bus.start;
  assign w_load_last    = w_accept_load && (r_idx == LAST_IDX);
  assign w_emit_last    = (r_state == EMIT) && (r_idx == LAST_IDX);
  assign w_walk_char    = r_l[r_row];
  // LF step: row of the preceding character in the sorted first column.
  assign w_row_sum      = w_c_val + r_rank[r_row];
  assign w_clear        = w_emit_last || w_abort;

`ifdef IBWT_CHECK_EN
  logic r_err, r_term_seen;
  logic w_is_term, w_is_low, w_byte_bad, w_err_end;
  assign w_is_term  = (bus.input_string_char == TERM_CHAR);
  assign w_is_low   = (bus.input_string_char < TERM_CHAR);
  assign w_byte_bad = w_is_low || (w_is_term && r_term_seen);
  assign w_err_end  = r_err || w_byte_bad || !(r_term_seen || w_is_term);
  assign w_abort    = w_load_last && w_err_end;
  assign bus.err    = r_err;
`else
  assign w_abort    = 1'b0;
  assign bus.err    = 1'b0;
`endif

  ibwt_count_table #(.CNT_W(CNT_W)) u_count (
    .clk          (clk),
    .rst          (rst),
    .i_inc_en     (w_accept_first || w_accept_load),
    .i_inc_char   (bus.input_string_char),
    .o_old_cnt    (w_old_cnt),
    .i_clear      (w_clear),
    .i_prefix_en  (r_state == PREFIX),
    .i_prefix_k   (r_k),
    .i_lookup_char(w_walk_char),
    .o_c_val      (w_c_val)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_k     <= '0;
      r_row   <= '0;
      r_valid <= 1'b0;
      r_char  <= '0;
      r_busy  <= 1'b0;
`ifdef IBWT_CHECK_EN
      r_err       <= 1'b0;
      r_term_seen <= 1'b0;
`endif
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          r_busy <= bus.start;
          if (bus.start) begin
            r_state <= LOAD;
            r_idx   <= IDX_W'(1);
`ifdef IBWT_CHECK_EN
            r_err       <= w_is_low;
            r_term_seen <= w_is_term;
`endif
          end
        end
        LOAD: begin
          if (bus.start) begin
`ifdef IBWT_CHECK_EN
            r_err       <= r_err | w_byte_bad;
            r_term_seen <= r_term_seen | w_is_term;
`endif
            if (r_idx == LAST_IDX) begin
`ifdef IBWT_CHECK_EN
              r_err <= w_err_end;
`endif
              if (w_abort) begin
                r_state <= IDLE;
                r_busy  <= 1'b0;
              end else begin
                r_state <= PREFIX;
                r_k     <= '0;
              end
            end else begin
              r_idx <= r_idx + IDX_W'(1);
            end
          end
        end
        PREFIX: begin
          r_k <= r_k + 8'd1;
          if (r_k == 8'd255) begin
            r_state <= WALK;
            r_row   <= '0;
            r_idx   <= WALK_START;
          end
        end
        WALK: begin
          r_row <= w_row_sum[IDX_W-1:0];
          if (r_idx == '0) r_state <= FINAL;
          else             r_idx   <= r_idx - IDX_W'(1);
        end
        FINAL: begin
          r_state <= EMIT;
          r_idx   <= '0;
        end
        EMIT: begin
          r_valid <= 1'b1;
          r_char  <= r_out[r_idx];
          if (w_emit_last) r_state <= IDLE;
          else             r_idx   <= r_idx + IDX_W'(1);
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Byte stores: contents are always written before they are read in a block.
  always_ff @(posedge clk) begin
    if (w_accept_first) begin
      r_l[0]    <= bus.input_string_char;
      r_rank[0] <= w_old_cnt;
    end
    if (w_accept_load) begin
      r_l[r_idx]    <= bus.input_string_char;
      r_rank[r_idx] <= w_old_cnt;
    end
    if (r_state == WALK)  r_out[r_idx]    <= w_walk_char;
    if (r_state == FINAL) r_out[LAST_IDX] <= TERM_CHAR;
  end

  assign bus.output_string_char = r_char;
  assign bus.valid_out          = r_valid;
  assign bus.busy               = r_busy;
  assign bus.dbg_state          = r_state;
endmodule

// File: tb/tb_ibwt_top.sv
// tb_ibwt_top: directed bench for ibwt_top with two decoders (7- and 32-byte
// blocks). Drivers push the expected decoded string into a per-decoder queue;
// monitors pop and compare on every valid_out, and also check first-byte
// latency, burst length and busy release.
module tb_ibwt_top;
  import ibwt_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  ibwt_if bus7 ();
  ibwt_if bus32 ();

  ibwt_top #(.STRING_LEN(7), .TERM_CHAR(8'h24)) u_dut7 (
    .clk(clk), .rst(rst), .bus(bus7)
  );
  ibwt_top #(.STRING_LEN(32), .TERM_CHAR(8'h24)) u_dut32 (
    .clk(clk), .rst(rst), .bus(bus32)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q7[$];
  logic [7:0] exp_q32[$];
  logic [7:0] stim_q[$];
  int last_acc7  = 0;
  int last_acc32 = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- monitors ----------------
  int   run7 = 0, run32 = 0;
  logic pv7 = 1'b0, pv32 = 1'b0;

  always @(negedge clk) begin
    if (!rst) begin
      run7 = 0; pv7 = 1'b0;
    end else begin
      if (bus7.valid_out) begin
        if (run7 == 0) chk("lat7", cyc - last_acc7, 256 + 7 + 1);
        run7++;
        chk("q7_nonempty", exp_q7.size() > 0, 1);
        if (exp_q7.size() > 0) chk("byte7", bus7.output_string_char, exp_q7.pop_front());
      end else if (pv7) begin
        chk("run7", run7, 7);
        chk("busy_fall7", bus7.busy, 0);
        run7 = 0;
      end
      pv7 = bus7.valid_out;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      run32 = 0; pv32 = 1'b0;
    end else begin
      if (bus32.valid_out) begin
        if (run32 == 0) chk("lat32", cyc - last_acc32, 256 + 32 + 1);
        run32++;
        chk("q32_nonempty", exp_q32.size() > 0, 1);
        if (exp_q32.size() > 0) chk("byte32", bus32.output_string_char, exp_q32.pop_front());
      end else if (pv32) begin
        chk("run32", run32, 32);
        chk("busy_fall32", bus32.busy, 0);
        run32 = 0;
      end
      pv32 = bus32.valid_out;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic put(input int which, input logic st, input logic [7:0] b);
    if (which == 7) begin
      bus7.start = st; bus7.input_string_char = b;
    end else begin
      bus32.start = st; bus32.input_string_char = b;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic str2stim(input string s);
    stim_q.delete();
    for (int i = 0; i < s.len(); i++) stim_q.push_back(s[i]);
  endtask

  // Stream stim_q; a gap (start low) is inserted before byte indices ga and gb.
  task automatic send(input int which, input int ga, input int gb);
    for (int i = 0; i < stim_q.size(); i++) begin
      if (i == ga || i == gb) put(which, 1'b0, 8'h00);
      put(which, 1'b1, stim_q[i]);
    end
    if (which == 7) begin bus7.start = 1'b0;  last_acc7  = cyc; end
    else            begin bus32.start = 1'b0; last_acc32 = cyc; end
  endtask

  task automatic push_exp(input int which, input string s);
    for (int i = 0; i < s.len(); i++) begin
      if (which == 7) exp_q7.push_back(s[i]);
      else            exp_q32.push_back(s[i]);
    end
  endtask

  task automatic wait_idle(input int which, input int budget);
    bit done = 0;
    for (int i = 0; i < budget && !done; i++) begin
      wait_cycles(1);
      if (which == 7) done = !bus7.busy && (exp_q7.size() == 0);
      else            done = !bus32.busy && (exp_q32.size() == 0);
    end
    chk(which == 7 ? "idle_timeout7" : "idle_timeout32", done, 1);
    wait_cycles(2);
  endtask

  // Forward BWT used only to build the 32-byte stimulus from its known plaintext.
  function automatic bit rot_less(input string s, input int a, input int b);
    int n = s.len();
    for (int t = 0; t < n; t++) begin
      if (s[(a + t) % n] != s[(b + t) % n]) return s[(a + t) % n] < s[(b + t) % n];
    end
    return 1'b0;
  endfunction

  task automatic bwt_stim(input string s);
    int n = s.len();
    int sa[$];
    int tmp;
    for (int i = 0; i < n; i++) sa.push_back(i);
    for (int i = 1; i < n; i++) begin
      for (int j = i; j > 0 && rot_less(s, sa[j], sa[j-1]); j--) begin
        tmp = sa[j]; sa[j] = sa[j-1]; sa[j-1] = tmp;
      end
    end
    stim_q.delete();
    for (int i = 0; i < n; i++) stim_q.push_back(s[(sa[i] + n - 1) % n]);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus7.start = 1'b0;  bus7.input_string_char = 8'h00;
    bus32.start = 1'b0; bus32.input_string_char = 8'h00;
    wait_cycles(3);
    chk("rst_valid7", bus7.valid_out, 0);
    chk("rst_char7",  bus7.output_string_char, 0);
    chk("rst_busy7",  bus7.busy, 0);
    chk("rst_err7",   bus7.err, 0);
    chk("rst_state7", bus7.dbg_state, IDLE);
    chk("rst_busy32", bus32.busy, 0);
    rst = 1'b1;
    wait_cycles(2);

    // 1: basic banana decode
    str2stim("annb$aa");
    push_exp(7, "banana$");
    send(7, -1, -1);
    chk("busy_during7", bus7.busy, 1);
    wait_idle(7, 600);
    chk("err_clean7", bus7.err, 0);

    // 2: 32-byte block
    bwt_stim("mississipimississipimississipiq$");
    push_exp(32, "mississipimississipimississipiq$");
    send(32, -1, -1);
    wait_idle(32, 700);

    // 3: gaps inside the load
    str2stim("annb$aa");
    push_exp(7, "banana$");
    send(7, 2, 5);
    wait_idle(7, 600);

    // 4: junk start pulses during PREFIX and EMIT are ignored
    str2stim("annb$aa");
    push_exp(7, "banana$");
    send(7, -1, -1);
    wait_cycles(50);
    chk("state_prefix", bus7.dbg_state, PREFIX);
    put(7, 1'b1, 8'hff); put(7, 1'b1, 8'h00); put(7, 1'b1, 8'h24);
    bus7.start = 1'b0;
    begin
      bit seen = 0;
      for (int i = 0; i < 400 && !seen; i++) begin
        wait_cycles(1);
        seen = bus7.valid_out;
      end
      chk("emit_seen", seen, 1);
    end
    put(7, 1'b1, 8'h6e); put(7, 1'b1, 8'h24); put(7, 1'b1, 8'h61);
    bus7.start = 1'b0;
    wait_idle(7, 100);
    wait_cycles(20);
    chk("no_extra_busy", bus7.busy, 0);
    chk("no_extra_state", bus7.dbg_state, IDLE);

    // 5: reset in the middle of WALK, then a clean rerun
    str2stim("annb$aa");
    push_exp(7, "banana$");
    send(7, -1, -1);
    wait_cycles(256 + 3);
    chk("state_walk", bus7.dbg_state, WALK);
    rst = 1'b0;
    exp_q7.delete();
    #1;
    chk("rstmid_valid", bus7.valid_out, 0);
    chk("rstmid_busy",  bus7.busy, 0);
    wait_cycles(3);
    chk("rstmid_valid2", bus7.valid_out, 0);
    rst = 1'b1;
    wait_cycles(5);
    chk("after_rst_valid", bus7.valid_out, 0);
    push_exp(7, "banana$");
    send(7, -1, -1);
    wait_idle(7, 600);

`ifdef IBWT_CHECK_EN
    // 6: duplicated terminator aborts the block, next good block clears err
    str2stim("an$b$aa");
    send(7, -1, -1);
    wait_idle(7, 50);
    chk("err_set", bus7.err, 1);
    chk("err_busy", bus7.busy, 0);
    str2stim("annb$aa");
    push_exp(7, "banana$");
    send(7, -1, -1);
    chk("err_cleared", bus7.err, 0);
    wait_idle(7, 600);
    chk("err_after", bus7.err, 0);
`endif

    wait_cycles(5);
    chk("q7_drained", exp_q7.size(), 0);
    chk("q32_drained", exp_q32.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
